// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial system bus.
// Contents:
//   arb_state_t          - arbiter FSM state encoding (IDLE, BUSY)
//   sel_width()          - width of an owner index for a given master count (min 1)
//   ADDR_WIDTH/DATA_WIDTH - bus widths shared by the bridge and slaves
package serial_bus_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Owner index width; a single-bit index is kept even for degenerate counts.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_picker.sv
// Combinational round-robin picker.
// Ports:
//   req    [NUM_MASTERS] - eligible request vector
//   ptr    [SEL_WIDTH]   - index of the most recent winner
//   winner [SEL_WIDTH]   - first requester strictly after ptr, with wrap
//   valid                - high when any request is set
module rr_priority_picker
  import serial_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int SEL_WIDTH   = sel_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [SEL_WIDTH-1:0]   ptr,
  output logic [SEL_WIDTH-1:0]   winner,
  output logic                   valid
);

  logic [NUM_MASTERS-1:0] window_s;
  int                     first_s;
  int                     win_int_s;

  // Rotate a doubled copy of req so window bit 0 is the master after ptr,
  // then the lowest set window bit maps back to the winning index.
  always_comb begin
    window_s = NUM_MASTERS'({req, req} >> (int'(ptr) + 32'sd1));
    first_s  = 32'sd0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      first_s = window_s[k] ? k : first_s;
    end
    win_int_s = (int'(ptr) + 32'sd1 + first_s) % NUM_MASTERS;
    winner    = SEL_WIDTH'(win_int_s);
    valid     = |window_s;
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared serial bus with split-transaction support
// and an optional hold-timeout watchdog.
// Ports:
//   clk, rstn        - clock, asynchronous active-low reset
//   mbreq            - per-master level request, held for the whole transaction
//   mbgrant          - registered one-hot grant
//   msplit           - registered per-master split indication
//   ssplit           - slave split pulse (only acted on while BUSY)
//   split_release    - slave resume pulse for the split master
//   msel             - current/last owner index for the bus muxes
//   bus_busy         - high while a grant is active
//   timeout_err      - one-cycle pulse when the watchdog revokes a grant
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int SEL_WIDTH      = sel_width(NUM_MASTERS),
  parameter int MAX_HOLD       = 0,
  parameter int HOLD_CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] mbreq,
  output logic [NUM_MASTERS-1:0] mbgrant,
  output logic [NUM_MASTERS-1:0] msplit,
  input  logic                   ssplit,
  input  logic                   split_release,
  output logic [SEL_WIDTH-1:0]   msel,
  output logic                   bus_busy,
  output logic                   timeout_err
);

  localparam logic [NUM_MASTERS-1:0]    ONE_HOT0   = NUM_MASTERS'(1);
  localparam bit                        WDOG_EN    = (MAX_HOLD != 0);
  localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LIMIT = HOLD_CNT_WIDTH'(MAX_HOLD - 1);

  arb_state_t                state_r;
  logic [NUM_MASTERS-1:0]    grant_r;
  logic [NUM_MASTERS-1:0]    msplit_r;
  logic [SEL_WIDTH-1:0]      msel_r;
  logic                      busy_r;
  logic                      timeout_r;
  logic [SEL_WIDTH-1:0]      rr_ptr_r;
  logic                      split_pending_r;
  logic [SEL_WIDTH-1:0]      split_idx_r;
  logic                      boost_r;
  logic [SEL_WIDTH-1:0]      boost_idx_r;
  logic [HOLD_CNT_WIDTH-1:0] hold_cnt_r;

  logic [NUM_MASTERS-1:0] split_mask_s;
  logic [NUM_MASTERS-1:0] elig_s;
  logic [SEL_WIDTH-1:0]   pick_idx_s;
  logic                   pick_valid_s;
  logic [SEL_WIDTH-1:0]   win_idx_s;
  logic                   arb_s;
  logic                   release_s;
  logic                   pending_eff_s;
  logic                   owner_req_s;

  rr_priority_picker #(
    .NUM_MASTERS(NUM_MASTERS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_picker (
    .req   (elig_s),
    .ptr   (rr_ptr_r),
    .winner(pick_idx_s),
    .valid (pick_valid_s)
  );

  // Eligibility, boost override and event qualifiers for the state update.
  always_comb begin
    if (split_pending_r) begin
      split_mask_s = ONE_HOT0 << split_idx_r;
    end else begin
      split_mask_s = '0;
    end
    elig_s    = mbreq & ~split_mask_s;
    arb_s     = (state_r == IDLE) && pick_valid_s;
    // A freshly released master wins its first arbitration if it still asks.
    if (boost_r && elig_s[boost_idx_r]) begin
      win_idx_s = boost_idx_r;
    end else begin
      win_idx_s = pick_idx_s;
    end
    release_s     = split_release && split_pending_r;
    // Release is handled before a same-cycle split, so it frees the split slot.
    pending_eff_s = split_pending_r && !split_release;
    owner_req_s   = mbreq[msel_r];
  end

  // Arbiter FSM, split bookkeeping, watchdog and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r         <= IDLE;
      grant_r         <= '0;
      msplit_r        <= '0;
      msel_r          <= '0;
      busy_r          <= 1'b0;
      timeout_r       <= 1'b0;
      rr_ptr_r        <= '0;
      split_pending_r <= 1'b0;
      split_idx_r     <= '0;
      boost_r         <= 1'b0;
      boost_idx_r     <= '0;
      hold_cnt_r      <= '0;
    end else begin
      timeout_r <= 1'b0;

      if (release_s) begin
        msplit_r        <= '0;
        split_pending_r <= 1'b0;
      end else begin
        split_pending_r <= split_pending_r;
      end

      case (state_r)
        IDLE: begin
          if (arb_s) begin
            grant_r    <= ONE_HOT0 << win_idx_s;
            msel_r     <= win_idx_s;
            rr_ptr_r   <= win_idx_s;
            busy_r     <= 1'b1;
            hold_cnt_r <= '0;
            state_r    <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (!owner_req_s) begin
            // Owner drop outranks a same-cycle split or timeout.
            grant_r <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (ssplit && !pending_eff_s) begin
            grant_r         <= '0;
            busy_r          <= 1'b0;
            msplit_r        <= ONE_HOT0 << msel_r;
            split_pending_r <= 1'b1;
            split_idx_r     <= msel_r;
            state_r         <= IDLE;
          end else if (WDOG_EN && (hold_cnt_r == HOLD_LIMIT)) begin
            grant_r   <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
            state_r   <= IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_CNT_WIDTH'(1);
          end
        end
        default: begin
          grant_r <= '0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase

      // Boost is armed by a release and consumed by the next arbitration;
      // a release in the same cycle as an arbitration keeps it for the next one.
      if (release_s) begin
        boost_r     <= 1'b1;
        boost_idx_r <= split_idx_r;
      end else if (arb_s) begin
        boost_r <= 1'b0;
      end else begin
        boost_r <= boost_r;
      end
    end
  end

  assign mbgrant     = grant_r;
  assign msplit      = msplit_r;
  assign msel        = msel_r;
  assign bus_busy    = busy_r;
  assign timeout_err = timeout_r;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: one instance without watchdog and
// one with MAX_HOLD=8, sharing clock and reset.
module tb_serial_bus_arbiter;

  logic       clk;
  logic       rstn;
  logic [1:0] mbreq;
  logic [1:0] mbgrant;
  logic [1:0] msplit;
  logic       ssplit;
  logic       split_release;
  logic [0:0] msel;
  logic       bus_busy;
  logic       timeout_err;

  logic [1:0] wd_req;
  logic [1:0] wd_grant;
  logic [1:0] wd_split;
  logic       wd_ssplit;
  logic       wd_release;
  logic [0:0] wd_sel;
  logic       wd_busy;
  logic       wd_terr;

  int checks = 0;
  int errors = 0;

  serial_bus_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(0)) dut (
    .clk(clk), .rstn(rstn), .mbreq(mbreq), .mbgrant(mbgrant), .msplit(msplit),
    .ssplit(ssplit), .split_release(split_release), .msel(msel),
    .bus_busy(bus_busy), .timeout_err(timeout_err)
  );

  serial_bus_arbiter #(.NUM_MASTERS(2), .MAX_HOLD(8)) dut_wd (
    .clk(clk), .rstn(rstn), .mbreq(wd_req), .mbgrant(wd_grant), .msplit(wd_split),
    .ssplit(wd_ssplit), .split_release(wd_release), .msel(wd_sel),
    .bus_busy(wd_busy), .timeout_err(wd_terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0; mbreq = 2'b00; ssplit = 1'b0; split_release = 1'b0;
    wd_req = 2'b00; wd_ssplit = 1'b0; wd_release = 1'b0;
    step(); step();
    chk("rst_grant", 32'(mbgrant), 32'h0);
    chk("rst_split", 32'(msplit), 32'h0);
    chk("rst_sel", 32'(msel), 32'h0);
    chk("rst_busy", 32'(bus_busy), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);
    rstn = 1'b1;
    step();
    chk("idle_no_req", 32'(mbgrant), 32'h0);

    // Single master: granted one cycle after request, held 10 cycles.
    mbreq = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("single_grant", 32'(mbgrant), 32'h1);
      chk("single_busy", 32'(bus_busy), 32'h1);
    end
    chk("single_sel", 32'(msel), 32'h0);
    mbreq = 2'b00;
    step();
    chk("single_drop_grant", 32'(mbgrant), 32'h0);
    chk("single_drop_busy", 32'(bus_busy), 32'h0);

    // Contention: rr pointer is 0, so master1 first, then alternate.
    mbreq = 2'b11;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] oh;
      oh = (r % 2 == 0) ? 2'b10 : 2'b01;
      step();
      chk("rr_grant", 32'(mbgrant), 32'(oh));
      chk("rr_sel", 32'(msel), (r % 2 == 0) ? 32'h1 : 32'h0);
      for (int i = 0; i < 4; i++) begin
        step();
        chk("rr_hold", 32'(mbgrant), 32'(oh));
      end
      mbreq = ~oh;
      step();
      chk("rr_dead_grant", 32'(mbgrant), 32'h0);
      chk("rr_dead_busy", 32'(bus_busy), 32'h0);
      mbreq = 2'b11;
    end

    // Split: master0 owns, slave splits it, master1 takes over.
    mbreq = 2'b01;
    step();
    chk("sp_m0_grant", 32'(mbgrant), 32'h1);
    mbreq = 2'b11; ssplit = 1'b1;
    step();
    ssplit = 1'b0;
    chk("sp_grant_off", 32'(mbgrant), 32'h0);
    chk("sp_msplit", 32'(msplit), 32'h1);
    step();
    chk("sp_m1_grant", 32'(mbgrant), 32'h2);
    chk("sp_m1_msplit", 32'(msplit), 32'h1);
    step();
    chk("sp_m1_hold", 32'(mbgrant), 32'h2);
    ssplit = 1'b1;
    step();
    ssplit = 1'b0;
    chk("sp_second_ignored", 32'(mbgrant), 32'h2);
    chk("sp_second_msplit", 32'(msplit), 32'h1);
    step();
    chk("sp_m1_still", 32'(mbgrant), 32'h2);
    mbreq = 2'b01;
    step();
    chk("sp_m1_done", 32'(mbgrant), 32'h0);
    step();
    chk("sp_mask_m0", 32'(mbgrant), 32'h0);
    chk("sp_mask_msplit", 32'(msplit), 32'h1);
    split_release = 1'b1;
    step();
    split_release = 1'b0;
    chk("sp_rel_msplit", 32'(msplit), 32'h0);
    chk("sp_rel_grant", 32'(mbgrant), 32'h0);
    mbreq = 2'b11;
    step();
    chk("sp_boost_m0", 32'(mbgrant), 32'h1);
    chk("sp_boost_sel", 32'(msel), 32'h0);
    mbreq = 2'b10;
    step();
    chk("sp_m0_drop", 32'(mbgrant), 32'h0);

    // Reset mid-BUSY with master1 split and master0 owning.
    step();
    chk("rs_m1_grant", 32'(mbgrant), 32'h2);
    mbreq = 2'b11; ssplit = 1'b1;
    step();
    ssplit = 1'b0;
    chk("rs_msplit", 32'(msplit), 32'h2);
    step();
    chk("rs_m0_grant", 32'(mbgrant), 32'h1);
    chk("rs_m0_msplit", 32'(msplit), 32'h2);
    #2 rstn = 1'b0;
    #1;
    chk("rs_async_grant", 32'(mbgrant), 32'h0);
    chk("rs_async_msplit", 32'(msplit), 32'h0);
    chk("rs_async_busy", 32'(bus_busy), 32'h0);
    chk("rs_async_sel", 32'(msel), 32'h0);
    step();
    rstn = 1'b1; mbreq = 2'b10;
    step();
    chk("rs_regrant", 32'(mbgrant), 32'h2);
    chk("rs_regrant_sel", 32'(msel), 32'h1);

    // Release with nothing pending has no effect.
    split_release = 1'b1;
    step();
    split_release = 1'b0;
    chk("rel_ignored_msplit", 32'(msplit), 32'h0);
    chk("rel_ignored_grant", 32'(mbgrant), 32'h2);
    mbreq = 2'b00;

    // Watchdog: 8 BUSY cycles then revoke, single timeout pulse, re-grant.
    wd_req = 2'b10;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("wd_hold", 32'(wd_grant), 32'h2);
      chk("wd_no_terr", 32'(wd_terr), 32'h0);
    end
    step();
    chk("wd_revoke", 32'(wd_grant), 32'h0);
    chk("wd_terr_pulse", 32'(wd_terr), 32'h1);
    chk("wd_busy_off", 32'(wd_busy), 32'h0);
    step();
    chk("wd_regrant", 32'(wd_grant), 32'h2);
    chk("wd_terr_once", 32'(wd_terr), 32'h0);
    chk("wd_sel", 32'(wd_sel), 32'h1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("wd_hold2", 32'(wd_grant), 32'h2);
    end
    // Drop on the timeout cycle: drop wins, no timeout pulse.
    wd_req = 2'b00;
    step();
    chk("wd_drop_grant", 32'(wd_grant), 32'h0);
    chk("wd_drop_terr", 32'(wd_terr), 32'h0);
    step();
    chk("wd_idle_terr", 32'(wd_terr), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
